ldm_stm_sequencer: RTL and testbench

Multi-cycle sequencer for ARM block-transfer instructions (LDM/STM). It walks a 16-bit register list and drives the register file's read port (STM) or write port (LDM). It also generates word addresses and handshakes toward data memory, then performs optional base writeback. It sits directly upstream of the `registers` block and drives its register-number, write-data and `regwrite` inputs for the duration of the instruction.

---
 rtl/arm_lsm_pkg.sv | 23 ++
 rtl/lsm_priority_encoder.sv | 20 ++
 rtl/ldm_stm_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_ldm_stm_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_lsm_pkg.sv
// rtl/arm_lsm_pkg.sv - shared types, constants and helpers for the LDM/STM sequencer
package arm_lsm_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      XFER   = 2'd2,
      FINISH = 2'd3
   } lsm_state_t;

   localparam logic [3:0] REG_PC     = 4'd15;
   localparam int         WORD_BYTES = 4;

   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] cnt;
      cnt = 5'd0;
      for (int i = 0; i < 16; i++) begin
         cnt = cnt + {4'd0, v[i]};
      end
      return cnt;
   endfunction

endpackage

// File: rtl/lsm_priority_encoder.sv
// rtl/lsm_priority_encoder.sv - index of the lowest set bit of a 16-bit register mask
module lsm_priority_encoder (
   input  logic [15:0] mask,
   output logic [3:0]  index,
   output logic        valid
);

   // Scan from the top down so the lowest set bit is the last one to win.
   always_comb begin
      index = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (mask[i]) begin
            index = 4'(i);
         end
      end
   end

   assign valid = |mask;

endmodule

// File: rtl/ldm_stm_sequencer.sv
// rtl/ldm_stm_sequencer.sv - LDM/STM block-transfer sequencer driving the register file and data memory
// Optional feature macro: LSM_PC_LOAD_EN (pc_load pulse on an LDM that loads R15).
module ldm_stm_sequencer
   import arm_lsm_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              is_load,
   input  logic              up,
   input  logic              pre,
   input  logic              writeback,
   input  logic [3:0]        base_reg,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [15:0]       reg_list,
   output logic [3:0]        reg_num,
   input  logic [DATA_W-1:0] reg_read_data,
   output logic              regwrite,
   output logic [DATA_W-1:0] write_data,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              busy,
   output logic              done,
   output logic              pc_load
);

   lsm_state_t        state_q, state_d;
   logic              is_load_q, up_q, pre_q, wb_q;
   logic [3:0]        base_reg_q;
   logic [ADDR_W-1:0] base_q;
   logic [15:0]       list_q;
   logic [15:0]       mask_q;
   logic [4:0]        n_q;
   logic [ADDR_W-1:0] addr_q;

   logic [3:0]        cur_idx;
   logic              cur_valid;
   logic [4:0]        n_setup;
   logic [ADDR_W-1:0] span_setup;
   logic [ADDR_W-1:0] span_q;
   logic [ADDR_W-1:0] start_addr;
   logic [ADDR_W-1:0] wb_value;
   logic              wb_en;
   logic [15:0]       mask_next;
   logic              handshake;

   lsm_priority_encoder u_prio (
      .mask  (mask_q),
      .index (cur_idx),
      .valid (cur_valid)
   );

   assign n_setup    = popcount16(list_q);
   assign span_setup = ADDR_W'(n_setup) * ADDR_W'(WORD_BYTES);
   assign span_q     = ADDR_W'(n_q) * ADDR_W'(WORD_BYTES);

   // Lowest register always lands at the lowest address, so descending modes start below base.
   always_comb begin
      case ({up_q, pre_q})
         2'b10:   start_addr = base_q;
         2'b11:   start_addr = base_q + ADDR_W'(WORD_BYTES);
         2'b00:   start_addr = base_q - span_setup + ADDR_W'(WORD_BYTES);
         default: start_addr = base_q - span_setup;
      endcase
   end

   assign wb_value  = up_q ? (base_q + span_q) : (base_q - span_q);
   // A loaded base register keeps the loaded value instead of the writeback.
   assign wb_en     = wb_q && (n_q != 5'd0) && !(is_load_q && list_q[base_reg_q]);
   assign mask_next = mask_q & (mask_q - 16'd1);
   assign handshake = (state_q == XFER) && cur_valid && mem_ready;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         is_load_q  <= 1'b0;
         up_q       <= 1'b0;
         pre_q      <= 1'b0;
         wb_q       <= 1'b0;
         base_reg_q <= 4'd0;
         base_q     <= '0;
         list_q     <= 16'd0;
         mask_q     <= 16'd0;
         n_q        <= 5'd0;
         addr_q     <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (start) begin
                  is_load_q  <= is_load;
                  up_q       <= up;
                  pre_q      <= pre;
                  wb_q       <= writeback;
                  base_reg_q <= base_reg;
                  base_q     <= base_addr;
                  list_q     <= reg_list;
               end
            end
            SETUP: begin
               n_q    <= n_setup;
               addr_q <= start_addr;
               mask_q <= list_q;
            end
            XFER: begin
               if (handshake) begin
                  mask_q <= mask_next;
                  addr_q <= addr_q + ADDR_W'(WORD_BYTES);
               end
            end
            default: begin
               mask_q <= 16'd0;
            end
         endcase
      end
   end

   always_comb begin
      state_d    = state_q;
      reg_num    = 4'd0;
      regwrite   = 1'b0;
      write_data = '0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      done       = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SETUP;
            end
         end
         SETUP: begin
            state_d = (n_setup == 5'd0) ? FINISH : XFER;
         end
         XFER: begin
            if (cur_valid) begin
               mem_req  = 1'b1;
               mem_addr = addr_q;
               reg_num  = cur_idx;
               if (is_load_q) begin
                  regwrite   = mem_ready;
                  write_data = mem_rdata;
               end else begin
                  mem_we    = 1'b1;
                  mem_wdata = reg_read_data;
               end
            end
            if (handshake && (mask_next == 16'd0)) begin
               state_d = FINISH;
            end
         end
         default: begin
            done    = 1'b1;
            state_d = IDLE;
            if (wb_en) begin
               reg_num    = base_reg_q;
               regwrite   = 1'b1;
               write_data = DATA_W'(wb_value);
            end
         end
      endcase
   end

   assign busy = (state_q != IDLE);

`ifdef LSM_PC_LOAD_EN
   assign pc_load = (state_q == FINISH) && is_load_q && list_q[REG_PC];
`else
   assign pc_load = 1'b0;
`endif

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// tb/tb_ldm_stm_sequencer.sv - self-checking bench for ldm_stm_sequencer
module tb_ldm_stm_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic        start, is_load, up, pre, writeback;
   logic [3:0]  base_reg;
   logic [31:0] base_addr;
   logic [15:0] reg_list;
   logic [3:0]  reg_num;
   logic [31:0] reg_read_data;
   logic        regwrite;
   logic [31:0] write_data;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_ready;
   logic        busy, done, pc_load;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] tb_regs [16];

   typedef struct {
      logic        is_load, up, pre, wb;
      logic [3:0]  base_reg;
      logic [31:0] base;
      logic [15:0] list;
      int          wait_idx, wait_cyc;
      logic [31:0] exp_first;
      logic        exp_wb;
      logic [31:0] exp_wb_val;
      int          exp_lat;
   } vec_t;

   ldm_stm_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
      .clock(clock), .reset(reset), .start(start), .is_load(is_load), .up(up), .pre(pre),
      .writeback(writeback), .base_reg(base_reg), .base_addr(base_addr), .reg_list(reg_list),
      .reg_num(reg_num), .reg_read_data(reg_read_data), .regwrite(regwrite),
      .write_data(write_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy),
      .done(done), .pc_load(pc_load)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, a[31:16]};
   endfunction

   assign reg_read_data = tb_regs[reg_num];
   assign mem_rdata     = mem_word(mem_addr);

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic ld, input logic u, input logic p, input logic wb,
                               input logic [3:0] br, input logic [31:0] base, input logic [15:0] list,
                               input int widx, input int wcyc, input logic [31:0] ef,
                               input logic ewb, input logic [31:0] ewv, input int elat);
      vec_t v;
      v.is_load = ld; v.up = u; v.pre = p; v.wb = wb; v.base_reg = br; v.base = base;
      v.list = list; v.wait_idx = widx; v.wait_cyc = wcyc; v.exp_first = ef;
      v.exp_wb = ewb; v.exp_wb_val = ewv; v.exp_lat = elat;
      return v;
   endfunction

   // Runs one instruction and compares everything against a list/arithmetic model of the transfer.
   task automatic run_op(input vec_t v, output logic [31:0] obs_first, output logic obs_wb,
                         output logic [31:0] obs_wb_val, output int obs_lat);
      int          n, lat_exp, waits, xfer_idx, waited, req_cycles;
      logic [31:0] lo, span;
      logic        wb_exp, pc_exp, prev_stall, got_done;
      logic [31:0] prev_addr, prev_wdata;
      logic [3:0]  prev_rn;
      logic [3:0]  exp_regs[$];
      logic [31:0] o_addr[$];
      logic        o_we[$];
      logic [31:0] o_wd[$];
      logic [3:0]  o_rn[$];
      logic [3:0]  w_num[$];
      logic [31:0] w_data[$];

      n    = $countones(v.list);
      span = 32'(n) * 32'd4;
      if (v.up) lo = v.pre ? v.base + 32'd4 : v.base;
      else      lo = v.pre ? v.base - span : v.base - span + 32'd4;
      for (int r = 0; r < 16; r++) if (v.list[r]) exp_regs.push_back(4'(r));
      waits   = (v.wait_idx >= 0 && v.wait_idx < n) ? v.wait_cyc : 0;
      lat_exp = n + 2 + waits;
      wb_exp  = v.wb && (n != 0) && !(v.is_load && v.list[v.base_reg]);
`ifdef LSM_PC_LOAD_EN
      pc_exp  = v.is_load && v.list[15];
`else
      pc_exp  = 1'b0;
`endif

      @(negedge clock);
      is_load = v.is_load; up = v.up; pre = v.pre; writeback = v.wb;
      base_reg = v.base_reg; base_addr = v.base; reg_list = v.list;
      start = 1'b1; mem_ready = 1'b0;
      @(posedge clock);

      xfer_idx = 0; waited = 0; req_cycles = 0; prev_stall = 1'b0; got_done = 1'b0;
      prev_addr = '0; prev_wdata = '0; prev_rn = '0;
      obs_first = '0; obs_wb = 1'b0; obs_wb_val = '0; obs_lat = 0;
      for (int i = 1; i <= 200 && !got_done; i++) begin
         @(negedge clock);
         start     = $urandom_range(0, 1) == 1;
         base_addr = $urandom;
         reg_list  = 16'($urandom);
         base_reg  = 4'($urandom);
         is_load   = $urandom_range(0, 1) == 1;
         if (mem_req) begin
            if (xfer_idx == v.wait_idx && waited < v.wait_cyc) begin
               mem_ready = 1'b0;
               waited++;
            end else begin
               mem_ready = 1'b1;
            end
         end else begin
            mem_ready = $urandom_range(0, 1) == 1;
         end
         #1;
         if (prev_stall) begin
            check("hold_req", {63'd0, mem_req}, 64'd1);
            check("hold_addr", {32'd0, mem_addr}, {32'd0, prev_addr});
            check("hold_regnum", {60'd0, reg_num}, {60'd0, prev_rn});
            check("hold_wdata", {32'd0, mem_wdata}, {32'd0, prev_wdata});
         end
         if (done) begin
            got_done   = 1'b1;
            obs_lat    = i;
            obs_wb     = regwrite;
            obs_wb_val = write_data;
            check("done_no_req", {63'd0, mem_req}, 64'd0);
            if (regwrite) check("wb_regnum", {60'd0, reg_num}, {60'd0, v.base_reg});
            check("pc_load", {63'd0, pc_load}, {63'd0, pc_exp});
         end else begin
            check("pc_load_idle", {63'd0, pc_load}, 64'd0);
            if (regwrite) begin
               w_num.push_back(reg_num);
               w_data.push_back(write_data);
            end
            if (mem_req) begin
               req_cycles++;
               if (mem_ready) begin
                  o_addr.push_back(mem_addr);
                  o_we.push_back(mem_we);
                  o_wd.push_back(mem_wdata);
                  o_rn.push_back(reg_num);
                  xfer_idx++;
               end
            end
         end
         prev_stall = mem_req && !mem_ready;
         prev_addr  = mem_addr;
         prev_rn    = reg_num;
         prev_wdata = mem_wdata;
      end
      check("done_seen", {63'd0, got_done}, 64'd1);

      @(negedge clock);
      start = 1'b0; mem_ready = 1'b0;
      #1;
      check("busy_after", {63'd0, busy}, 64'd0);
      check("done_single", {63'd0, done}, 64'd0);

      check("latency", 64'(obs_lat), 64'(lat_exp));
      check("req_cycles", 64'(req_cycles), 64'(n + waits));
      check("xfer_count", 64'(o_addr.size()), 64'(n));
      check("regwr_count", 64'(w_num.size()), v.is_load ? 64'(n) : 64'd0);
      check("wb_flag", {63'd0, obs_wb}, {63'd0, wb_exp});
      if (wb_exp) check("wb_value", {32'd0, obs_wb_val}, {32'd0, v.up ? v.base + span : v.base - span});
      if (o_addr.size() > 0) obs_first = o_addr[0];
      for (int k = 0; k < n && k < o_addr.size(); k++) begin
         check("addr", {32'd0, o_addr[k]}, {32'd0, lo + 32'(k) * 32'd4});
         check("xfer_reg", {60'd0, o_rn[k]}, {60'd0, exp_regs[k]});
         check("mem_we", {63'd0, o_we[k]}, {63'd0, !v.is_load});
         if (!v.is_load) check("store_data", {32'd0, o_wd[k]}, {32'd0, tb_regs[exp_regs[k]]});
         if (v.is_load && k < w_num.size()) begin
            check("load_reg", {60'd0, w_num[k]}, {60'd0, exp_regs[k]});
            check("load_data", {32'd0, w_data[k]}, {32'd0, mem_word(lo + 32'(k) * 32'd4)});
         end
      end
   endtask

   initial begin
      vec_t        tbl [9];
      vec_t        rv;
      logic [31:0] f, wv;
      logic        w;
      int          lat;

      for (int i = 0; i < 16; i++) tb_regs[i] = 32'hA000_0000 + 32'(i) * 32'h0101_0111;
      reset = 1'b1; start = 1'b0; is_load = 1'b0; up = 1'b0; pre = 1'b0; writeback = 1'b0;
      base_reg = 4'd0; base_addr = '0; reg_list = '0; mem_ready = 1'b0;

      tbl[0] = mk(0, 1, 0, 1, 4'd13, 32'h1000, 16'h000B, -1, 0, 32'h1000, 1, 32'h100C, 5);
      tbl[1] = mk(1, 0, 1, 1, 4'd13, 32'h2000, 16'h00F0, -1, 0, 32'h1FF0, 1, 32'h1FF0, 6);
      tbl[2] = mk(0, 1, 0, 1, 4'd13, 32'h1000, 16'h000B,  1, 2, 32'h1000, 1, 32'h100C, 7);
      tbl[3] = mk(0, 1, 0, 1, 4'd13, 32'h1000, 16'h0000, -1, 0, 32'h0000, 0, 32'h0000, 2);
      tbl[4] = mk(1, 1, 0, 1, 4'd2,  32'h3000, 16'h0004, -1, 0, 32'h3000, 0, 32'h0000, 3);
      tbl[5] = mk(1, 1, 1, 0, 4'd1,  32'h4000, 16'h8001, -1, 0, 32'h4004, 0, 32'h0000, 4);
      tbl[6] = mk(0, 0, 0, 1, 4'd5,  32'h0100, 16'h0003, -1, 0, 32'h00FC, 1, 32'h00F8, 4);
      tbl[7] = mk(0, 0, 1, 1, 4'd8,  32'h0004, 16'h0007, -1, 0, 32'hFFFF_FFF8, 1, 32'hFFFF_FFF8, 5);
      tbl[8] = mk(1, 1, 0, 1, 4'd9,  32'h5000, 16'h0006,  1, 2, 32'h5000, 1, 32'h5008, 6);

      repeat (2) @(posedge clock);
      @(negedge clock);
      check("rst_ctrl", {58'd0, mem_req, mem_we, regwrite, busy, done, pc_load}, 64'd0);
      check("rst_data", {mem_addr, write_data}, 64'd0);
      reset = 1'b0;
      #1;
      check("idle_ctrl", {58'd0, mem_req, mem_we, regwrite, busy, done, pc_load}, 64'd0);
      check("idle_regnum", {60'd0, reg_num}, 64'd0);

      for (int k = 0; k < 9; k++) begin
         run_op(tbl[k], f, w, wv, lat);
         if (tbl[k].list != 16'd0) check("tbl_first_addr", {32'd0, f}, {32'd0, tbl[k].exp_first});
         check("tbl_wb", {63'd0, w}, {63'd0, tbl[k].exp_wb});
         if (tbl[k].exp_wb) check("tbl_wb_val", {32'd0, wv}, {32'd0, tbl[k].exp_wb_val});
         check("tbl_latency", 64'(lat), 64'(tbl[k].exp_lat));
      end

      // Reset while stalled in the middle of a store burst.
      @(negedge clock);
      is_load = 1'b0; up = 1'b1; pre = 1'b0; writeback = 1'b1; base_reg = 4'd13;
      base_addr = 32'h6000; reg_list = 16'h00FF; start = 1'b1; mem_ready = 1'b0;
      @(negedge clock);
      start = 1'b0;
      repeat (3) @(negedge clock);
      #1;
      check("mid_xfer_req", {63'd0, mem_req}, 64'd1);
      reset = 1'b1;
      #1;
      check("abort_ctrl", {58'd0, mem_req, mem_we, regwrite, busy, done, pc_load}, 64'd0);
      check("abort_addr", {32'd0, mem_addr}, 64'd0);
      check("abort_data", {mem_wdata, write_data}, 64'd0);
      check("abort_regnum", {60'd0, reg_num}, 64'd0);
      mem_ready = 1'b1;
      @(negedge clock);
      check("abort_hold", {61'd0, mem_req, regwrite, busy}, 64'd0);
      reset = 1'b0;
      mem_ready = 1'b0;
      #1;
      check("abort_idle", {61'd0, mem_req, regwrite, busy}, 64'd0);
      run_op(tbl[0], f, w, wv, lat);
      check("post_rst_first", {32'd0, f}, 64'h1000);

      for (int k = 0; k < 40; k++) begin
         rv = mk($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, 4'($urandom), $urandom,
                 ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom),
                 int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), 32'd0, 1'b0, 32'd0, 0);
         run_op(rv, f, w, wv, lat);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
